// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
//
// Multi-cycle operation controller for the calculator datapath. One external
// combinational 8-bit ripple adder (carry-in tied to 0) is shared across three
// operations:
//   ADD : one pass, regA + regB
//   SUB : negate pass (~regB + 1 into regB), then the ADD pass
//   MUL : unsigned 8-step shift-add, using the adder for acc_hi + partial
// The operation ends with a one-cycle done pulse and a registered 16-bit
// result. The result is held until the next accepted operation overwrites it.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        request strobe, sampled only in IDLE
//   op           in   2        00 ADD, 01 SUB, 10 MUL, 11 reserved (err)
//   opa          in   WIDTH    operand A (minuend / multiplicand)
//   opb          in   WIDTH    operand B (subtrahend / multiplier)
//   busy         out  1        high in NEG, ADD, MUL
//   done         out  1        one-cycle completion pulse
//   err          out  1        high together with done for the reserved op
//   result       out  2*WIDTH  registered result
//   carry_out    out  1        adder carry of the final pass (ADD/SUB), 0 for MUL
//   overflow     out  1        signed overflow of the final pass (ADD/SUB), 0 for MUL
//   adder_a      out  WIDTH    shared adder input a
//   adder_b      out  WIDTH    shared adder input b
//   adder_sum    in   WIDTH    shared adder sum
//   adder_carry  in   1        shared adder carry out
// ---------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               overflow,
  output logic [WIDTH-1:0]   adder_a,
  output logic [WIDTH-1:0]   adder_b,
  input  logic [WIDTH-1:0]   adder_sum,
  input  logic               adder_carry
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NEG  = 3'd1,
    S_ADD  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [WIDTH-1:0]   reg_a;
  logic [WIDTH-1:0]   reg_b;
  logic [1:0]         reg_op;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] result_q;
  logic               carry_q;
  logic               ovf_q;

  // Next accumulator value of one shift-add step: the adder carry and sum
  // become the new high half, and the multiplier half shifts right one bit,
  // dropping the bit that was just consumed.
  logic [2*WIDTH-1:0] mul_next;

  assign mul_next = {adder_carry, adder_sum, acc_lo[WIDTH-1:1]};

  // Signed two's-complement overflow of a + b = sum: both addends share a
  // sign and the sum's sign differs from it.
  function automatic logic add_overflow(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] sum);
    add_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_ADD:  state_d = S_ADD;
            OP_SUB:  state_d = S_NEG;
            OP_MUL:  state_d = S_MUL;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_NEG:   state_d = S_ADD;
      S_ADD:   state_d = S_DONE;
      S_MUL: begin
        if (cnt == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: status flags and the shared adder operand buses
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    adder_a = '0;
    adder_b = '0;
    unique case (state_q)
      S_NEG: begin
        busy    = 1'b1;
        adder_a = ~reg_b;
        adder_b = WIDTH'(1);
      end
      S_ADD: begin
        busy    = 1'b1;
        adder_a = reg_a;
        adder_b = reg_b;
      end
      S_MUL: begin
        busy    = 1'b1;
        adder_a = acc_hi;
        adder_b = acc_lo[0] ? reg_a : '0;
      end
      S_DONE: begin
        done = 1'b1;
        // The latched op stays valid through DONE, so err falls by itself
        // when the state leaves DONE.
        err  = (reg_op == OP_RSV);
      end
      default: begin
      end
    endcase
  end

  // Operand, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a    <= '0;
      reg_b    <= '0;
      reg_op   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            reg_a  <= opa;
            reg_b  <= opb;
            reg_op <= op;
            if (op == OP_MUL) begin
              acc_hi <= '0;
              acc_lo <= opb;
              cnt    <= '0;
            end
            if (op == OP_RSV) begin
              result_q <= '0;
            end
          end
        end
        S_NEG: begin
          // Two's-complement negation of the subtrahend; the ADD pass then
          // computes regA + (-regB).
          reg_b <= adder_sum;
        end
        S_ADD: begin
          result_q <= {{WIDTH{1'b0}}, adder_sum};
          carry_q  <= adder_carry;
          ovf_q    <= add_overflow(reg_a, reg_b, adder_sum);
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= mul_next;
          cnt              <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            result_q <= mul_next;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic [7:0]  adder_a;
  logic [7:0]  adder_b;
  logic [7:0]  adder_sum;
  logic        adder_carry;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        e;
    bit          chk_cv;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  calc_op_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_sum  (adder_sum),
    .adder_carry(adder_carry)
  );

  always #5 clk = ~clk;

  // External shared ripple adder, carry-in tied to 0
  assign {adder_carry, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model built from plain integer arithmetic
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t        m;
    logic [8:0]  s;
    logic [7:0]  nb;
    int          ss;
    m.e      = 1'b0;
    m.chk_cv = 1'b1;
    m.c      = 1'b0;
    m.v      = 1'b0;
    m.res    = 16'h0;
    m.lat    = 0;
    case (o)
      2'b00: begin
        s     = {1'b0, a} + {1'b0, b};
        ss    = int'($signed(a)) + int'($signed(b));
        m.res = {8'h00, s[7:0]};
        m.c   = s[8];
        m.v   = (ss > 127) || (ss < -128);
        m.lat = 2;
      end
      2'b01: begin
        nb    = 8'(256 - int'(b));
        s     = {1'b0, a} + {1'b0, nb};
        ss    = int'($signed(a)) + int'($signed(nb));
        m.res = {8'h00, s[7:0]};
        m.c   = s[8];
        m.v   = (ss > 127) || (ss < -128);
        m.lat = 3;
      end
      2'b10: begin
        m.res = 16'(int'(a) * int'(b));
        m.lat = 9;
      end
      default: begin
        m.e      = 1'b1;
        m.chk_cv = 1'b0;
        m.lat    = 1;
      end
    endcase
    return m;
  endfunction

  // Drive a start strobe in the current cycle (cycle 0) and push the expectation
  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input exp_t x);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    sb.push_back(x);
  endtask

  task automatic issue_plan(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] res, input logic c, input logic v,
                            input logic e, input int lat);
    exp_t x;
    x.res    = res;
    x.c      = c;
    x.v      = v;
    x.e      = e;
    x.chk_cv = (o != 2'b11);
    x.lat    = lat;
    issue(o, a, b, x);
  endtask

  // Wait for done (bounded), compare against the scoreboard head. Captures
  // busy and the adder buses seen in cycle 1. With poke set, start is pulsed
  // with a different request in every cycle while the op is running.
  task automatic wait_done(input string tag, input bit poke,
                           output logic c1_busy, output logic [7:0] c1_a, output logic [7:0] c1_b);
    int   cyc;
    exp_t x;
    tick();
    start   = 1'b0;
    cyc     = 1;
    c1_busy = busy;
    c1_a    = adder_a;
    c1_b    = adder_b;
    while (done !== 1'b1 && cyc < 20) begin
      if (poke) begin
        start = 1'b1;
        op    = 2'b00;
        opa   = 8'h01;
        opb   = 8'h01;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
      return;
    end
    x = sb.pop_front();
    if (done === 1'b1) begin
      check({tag, "_latency"}, 32'(cyc), 32'(x.lat));
      check({tag, "_result"}, 32'(result), 32'(x.res));
      check({tag, "_err"}, 32'(err), 32'(x.e));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (x.chk_cv) begin
        check({tag, "_carry"}, 32'(carry_out), 32'(x.c));
        check({tag, "_overflow"}, 32'(overflow), 32'(x.v));
      end
      tick();
      check({tag, "_done_after"}, 32'(done), 32'd0);
      check({tag, "_err_after"}, 32'(err), 32'd0);
    end
  endtask

  initial begin
    logic       b1;
    logic [7:0] a1;
    logic [7:0] bb1;
    exp_t       x;
    logic [1:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;
    int         seen;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    opa   = 8'h00;
    opb   = 8'h00;
    tick();
    tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_adder_a", 32'(adder_a), 32'd0);
    check("rst_adder_b", 32'(adder_b), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD 100 + 27
    issue_plan(2'b00, 8'd100, 8'd27, 16'h007F, 1'b0, 1'b0, 1'b0, 2);
    wait_done("add_100_27", 1'b0, b1, a1, bb1);
    check("add_100_27_busy_c1", 32'(b1), 32'd1);
    check("add_100_27_adder_a_c1", 32'(a1), 32'd100);

    // ADD 200 + 100 : carry, no overflow
    issue_plan(2'b00, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 1'b0, 2);
    wait_done("add_200_100", 1'b0, b1, a1, bb1);

    // ADD 100 + 100 : overflow, no carry
    issue_plan(2'b00, 8'd100, 8'd100, 16'h00C8, 1'b0, 1'b1, 1'b0, 2);
    wait_done("add_100_100", 1'b0, b1, a1, bb1);

    // SUB 5 - 7 : negate pass drives ~7 and 1
    issue_plan(2'b01, 8'd5, 8'd7, 16'h00FE, 1'b0, 1'b0, 1'b0, 3);
    wait_done("sub_5_7", 1'b0, b1, a1, bb1);
    check("sub_5_7_adder_a_c1", 32'(a1), 32'h00F8);
    check("sub_5_7_adder_b_c1", 32'(bb1), 32'h0001);
    check("sub_5_7_busy_c1", 32'(b1), 32'd1);

    // SUB 0x80 - 1 : overflow
    issue_plan(2'b01, 8'h80, 8'h01, 16'h007F, 1'b1, 1'b1, 1'b0, 3);
    wait_done("sub_80_1", 1'b0, b1, a1, bb1);

    // SUB 9 - 0 : negation of 0 is 0, no carry from the final add
    issue_plan(2'b01, 8'd9, 8'd0, 16'h0009, 1'b0, 1'b0, 1'b0, 3);
    wait_done("sub_9_0", 1'b0, b1, a1, bb1);

    // MUL 255 * 255 with start pulses ignored while running
    issue_plan(2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 1'b0, 9);
    wait_done("mul_255_255", 1'b1, b1, a1, bb1);

    // MUL 13 * 11
    issue_plan(2'b10, 8'd13, 8'd11, 16'h008F, 1'b0, 1'b0, 1'b0, 9);
    wait_done("mul_13_11", 1'b0, b1, a1, bb1);

    // Reserved op: immediate done+err, result cleared, no adder activity
    issue_plan(2'b11, 8'h55, 8'hAA, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    wait_done("rsv", 1'b0, b1, a1, bb1);
    check("rsv_adder_a_c1", 32'(a1), 32'd0);
    check("rsv_adder_b_c1", 32'(bb1), 32'd0);

    // Directed-random ops against the model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 2));
      ra = 8'($urandom_range(1, 255));
      rb = 8'($urandom_range(1, 255));
      x  = model(ro, ra, rb);
      issue(ro, ra, rb, x);
      wait_done($sformatf("rnd%0d_op%0d_%0h_%0h", i, ro, ra, rb), 1'b0, b1, a1, bb1);
    end

    // Make sure result is nonzero before the abort test
    issue_plan(2'b00, 8'd3, 8'd4, 16'h0007, 1'b0, 1'b0, 1'b0, 2);
    wait_done("add_3_4", 1'b0, b1, a1, bb1);

    // Reset in cycle 4 of MUL 255*255: outputs clear at once, no done
    start = 1'b1;
    op    = 2'b10;
    opa   = 8'd255;
    opb   = 8'd255;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_adder_a", 32'(adder_a), 32'd0);
    check("abort_adder_b", 32'(adder_b), 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Recovery: ADD 1 + 1
    issue_plan(2'b00, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 1'b0, 2);
    wait_done("add_1_1", 1'b0, b1, a1, bb1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
